program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Program-address generator for the MC14500B system; sits directly downstream of the reset sequencer and consumes its pc_reset output.
- Drives the program-memory address each cycle.
- Acts on the ICU's JMP and RTN flag outputs, with a small hardware return-address stack that provides subroutine call/return.
- Reports stack overflow/underflow as sticky error flags.

Parameters:
- ADDR_W, 8, width of program address and jump target.
- DEPTH, 4, number of return-address stack entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_reset  input  1  synchronous clear request from the reset sequencer; sampled on rising clk.
- en  input  1  advance enable; when low, state holds (except pc_reset).
- jmp  input  1  JMP flag from ICU: call to target.
- rtn  input  1  RTN flag from ICU: return from subroutine.
- target  input  ADDR_W  jump destination (operand field of current instruction).
- addr  output  ADDR_W  current program-memory address (registered).
- sp  output  $clog2(DEPTH)+1  number of valid stack entries.
- ovf  output  1  sticky: a call was made with the stack full.
- unf  output  1  sticky: a return was made with the stack empty.

Behaviour:
- Async reset (reset=1):
  - addr=0, sp=0, ovf=0, unf=0.
  - Stack contents are don't-care.
  - Takes effect immediately, independent of clk; reset mid-call/return discards everything.
- Priority at each rising edge: pc_reset > !en > jmp > rtn > increment.
- pc_reset=1:
  - addr←0, sp←0, ovf←0, unf←0.
  - Overrides en, jmp and rtn in the same cycle.
  - Held for multiple cycles, addr stays 0.
  - First post-release cycle behaves normally, so memory address 0 is fetched first.
- en=0 (no pc_reset): all registers hold; jmp/rtn ignored.
- jmp=1, en=1:
  - addr←target.
  - If sp<DEPTH: stack[sp]←addr+1 (mod 2^ADDR_W), sp←sp+1.
  - If sp==DEPTH: no push, sp holds, ovf←1, addr←target still.
- rtn=1, jmp=0, en=1:
  - If sp>0: addr←stack[sp-1], sp←sp-1.
  - If sp==0: addr←addr+1, unf←1, sp stays 0.
- jmp=1 and rtn=1 together: jmp wins, rtn ignored, no error flagged.
- Otherwise with en=1: addr←addr+1, wrapping from 2^ADDR_W-1 to 0; wrap is not an error.
- Return-address wrap: a jmp at addr=2^ADDR_W-1 pushes 0.
- Latency:
  - The new addr is visible one cycle after jmp/rtn/increment is sampled.
  - No combinational path from any input to addr, sp, ovf or unf.
- ovf/unf:
  - Once set, remain 1 until reset or pc_reset.
  - Never cleared by a subsequent successful operation.
- Stack storage is plain registers (no memory macro).
- LIFO order: exactly DEPTH nested calls must return in reverse order.

Test Plan:
- Reset release: reset=1 then 0, en=1, 5 cycles → addr 0,1,2,3,4, sp=0, ovf=unf=0. Then async reset pulse between clock edges → addr=0 immediately.
- pc_reset: at addr=0x23, assert pc_reset for 2 cycles with jmp=1, target=0x80 → addr=0x00 both cycles, sp=0, no push. Release → 0x01 next.
- Call/return: at addr=0x10, jmp target=0x40 → addr=0x40, sp=1. Increment twice (0x41, 0x42). rtn → addr=0x11, sp=0.
- Nesting/overflow (DEPTH=4):
  - 4 jmps from 0x00,0x20,0x30,0x40 to 0x20,0x30,0x40,0x50 → sp=4.
  - Fifth jmp to 0x60 → addr=0x60, sp=4, ovf=1.
  - 4 rtns → addr 0x41,0x31,0x21,0x01, sp=0, ovf still 1.
- Underflow/wrap:
  - With sp=0, rtn at addr=0x05 → addr=0x06, unf=1.
  - Separately, at addr=0xFF, increment → 0x00.
  - At addr=0xFF, jmp to 0x10 then rtn → addr=0x00.
- en hold and conflict:
  - en=0 with jmp=1 for 3 cycles → addr and sp unchanged.
  - en=1, jmp=1, rtn=1, target=0x77 with sp=1 → addr=0x77, sp=2.

Source files
------------

// File: rtl/program_counter.sv
// Program-address generator for the MC14500B: increments, jumps and returns via a
// small register-based return-address stack with sticky overflow/underflow flags.
module program_counter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pc_reset,
    input  logic                     en,
    input  logic                     jmp,
    input  logic                     rtn,
    input  logic [ADDR_W-1:0]        target,
    output logic [ADDR_W-1:0]        addr,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     ovf,
    output logic                     unf
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] r_addr;
    logic [SP_W-1:0]   r_sp;
    logic              r_ovf;
    logic              r_unf;
    logic [ADDR_W-1:0] r_stack [DEPTH];

    logic [ADDR_W-1:0] w_addr_d;
    logic [SP_W-1:0]   w_sp_d;
    logic              w_ovf_d;
    logic              w_unf_d;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;

    assign w_full     = (r_sp == SP_W'(DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));

    // Priority: pc_reset > !en > jmp > rtn > increment
    always_comb begin
        w_addr_d = w_addr_inc;
        w_sp_d   = r_sp;
        w_ovf_d  = r_ovf;
        w_unf_d  = r_unf;
        w_push   = 1'b0;
        if (pc_reset) begin
            w_addr_d = '0;
            w_sp_d   = '0;
            w_ovf_d  = 1'b0;
            w_unf_d  = 1'b0;
        end else if (!en) begin
            w_addr_d = r_addr;
        end else if (jmp) begin
            w_addr_d = target;
            if (w_full) begin
                w_ovf_d = 1'b1;
            end else begin
                w_push = 1'b1;
                w_sp_d = r_sp + SP_W'(1);
            end
        end else if (rtn) begin
            if (w_empty) begin
                w_unf_d = 1'b1;
            end else begin
                w_addr_d = r_stack[w_pop_idx];
                w_sp_d   = r_sp - SP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_sp   <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_addr <= w_addr_d;
            r_sp   <= w_sp_d;
            r_ovf  <= w_ovf_d;
            r_unf  <= w_unf_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_addr_inc;
        end
    end

    assign addr = r_addr;
    assign sp   = r_sp;
    assign ovf  = r_ovf;
    assign unf  = r_unf;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus random stimulus,
// compared each cycle against a queue-based reference model.
module tb_program_counter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              pc_reset;
    logic              en;
    logic              jmp;
    logic              rtn;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        sp;
    logic              ovf;
    logic              unf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_addr;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    program_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_reset (pc_reset),
        .en       (en),
        .jmp      (jmp),
        .rtn      (rtn),
        .target   (target),
        .addr     (addr),
        .sp       (sp),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit pr, input bit e, input bit j, input bit r,
                              input int t);
        if (pr) begin
            model_reset();
        end else if (e) begin
            if (j) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_addr + 1) % 256);
                else m_ovf = 1'b1;
                m_addr = t;
            end else if (r) begin
                if (m_stk.size() > 0) begin
                    m_addr = m_stk.pop_back();
                end else begin
                    m_addr = (m_addr + 1) % 256;
                    m_unf  = 1'b1;
                end
            end else begin
                m_addr = (m_addr + 1) % 256;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".addr"}, 32'(addr), 32'(m_addr));
        chk({tag, ".sp"},   32'(sp),   32'(m_stk.size()));
        chk({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
        chk({tag, ".unf"},  32'(unf),  32'(m_unf));
    endtask

    // One clock: drive, step through the edge, sample 1 time unit later.
    task automatic cyc(input string tag, input bit pr, input bit e, input bit j, input bit r,
                       input int t);
        pc_reset = pr;
        en       = e;
        jmp      = j;
        rtn      = r;
        target   = ADDR_W'(t);
        @(posedge clk);
        #1;
        model_step(pr, e, j, r, t);
        check_model(tag);
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) cyc("inc", 0, 1, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; pc_reset = 1'b0; en = 1'b0; jmp = 1'b0; rtn = 1'b0; target = '0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        reset = 1'b0;

        // Reset release: 0,1,2,3,4
        cyc("rel0", 0, 1, 0, 0, 0);
        chk("rel0.const", 32'(addr), 32'h1);
        inc_n(3);
        chk("rel3.const", 32'(addr), 32'h4);

        // Async reset between edges
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async");
        chk("async.const", 32'(addr), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // pc_reset overrides jmp
        inc_n(35);
        chk("at23", 32'(addr), 32'h23);
        cyc("pcr0", 1, 1, 1, 0, 8'h80);
        cyc("pcr1", 1, 1, 1, 0, 8'h80);
        chk("pcr.const", 32'(addr), 32'h0);
        cyc("pcrel", 0, 1, 0, 0, 0);
        chk("pcrel.const", 32'(addr), 32'h1);

        // Call / return
        cyc("clr", 1, 1, 0, 0, 0);
        inc_n(16);
        cyc("call", 0, 1, 1, 0, 8'h40);
        chk("call.sp", 32'(sp), 32'h1);
        inc_n(2);
        cyc("ret", 0, 1, 0, 1, 0);
        chk("ret.const", 32'(addr), 32'h11);

        // Nesting and overflow
        cyc("clr2", 1, 1, 0, 0, 0);
        cyc("n1", 0, 1, 1, 0, 8'h20);
        cyc("n2", 0, 1, 1, 0, 8'h30);
        cyc("n3", 0, 1, 1, 0, 8'h40);
        cyc("n4", 0, 1, 1, 0, 8'h50);
        chk("full.sp", 32'(sp), 32'h4);
        cyc("n5", 0, 1, 1, 0, 8'h60);
        chk("ovf.const", 32'(ovf), 32'h1);
        cyc("r1", 0, 1, 0, 1, 0);
        chk("r1.const", 32'(addr), 32'h41);
        cyc("r2", 0, 1, 0, 1, 0);
        cyc("r3", 0, 1, 0, 1, 0);
        cyc("r4", 0, 1, 0, 1, 0);
        chk("r4.const", 32'(addr), 32'h01);

        // Underflow
        cyc("clr3", 1, 1, 0, 0, 0);
        inc_n(5);
        cyc("unf", 0, 1, 0, 1, 0);
        chk("unf.addr", 32'(addr), 32'h06);
        chk("unf.flag", 32'(unf), 32'h1);

        // Address wrap and return-address wrap
        cyc("clr4", 1, 1, 0, 0, 0);
        inc_n(255);
        cyc("wrap", 0, 1, 0, 0, 0);
        chk("wrap.const", 32'(addr), 32'h00);
        cyc("toFF", 0, 1, 1, 0, 8'hFF);
        cyc("jFF", 0, 1, 1, 0, 8'h10);
        cyc("rFF", 0, 1, 0, 1, 0);
        chk("rwrap.const", 32'(addr), 32'h00);

        // en hold and jmp/rtn conflict
        cyc("clr5", 1, 1, 0, 0, 0);
        cyc("j1", 0, 1, 1, 0, 8'h30);
        for (int i = 0; i < 3; i++) cyc("hold", 0, 0, 1, 0, 8'h99);
        chk("hold.addr", 32'(addr), 32'h30);
        cyc("both", 0, 1, 1, 1, 8'h77);
        chk("both.addr", 32'(addr), 32'h77);
        chk("both.sp", 32'(sp), 32'h2);
        chk("both.unf", 32'(unf), 32'h0);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            cyc("rand",
                ($urandom_range(63) == 0),
                ($urandom_range(7) != 0),
                ($urandom_range(3) == 0),
                ($urandom_range(2) == 0),
                int'($urandom_range(255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
